// File: rtl/arp_responder_mc.sv
// Multi-address ARP responder with a small learned IP->MAC cache and a one-cycle lookup port.
// Define ARP_GRATUITOUS_EN to enable gratuitous ARP announcements driven by the announce input.
module arp_responder_mc #(
   parameter int NUM_IP      = 2,
   parameter int CACHE_DEPTH = 4,
   parameter int STRICT_HDR  = 1
) (
   input  logic                 rx_clock,
   input  logic                 reset,
   input  logic                 rx_enable,
   input  logic [7:0]           rx_data,
   input  logic [47:0]          local_mac,
   input  logic [32*NUM_IP-1:0] local_ip,
   input  logic                 announce,
   input  logic                 tx_enable,
   output logic                 tx_request,
   output logic                 tx_active,
   output logic [7:0]           tx_data,
   output logic [47:0]          destination_mac,
   input  logic                 lookup_req,
   input  logic [31:0]          lookup_ip,
   output logic                 lookup_done,
   output logic                 lookup_hit,
   output logic [47:0]          lookup_mac
);

   localparam int KW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
   localparam int PW = $clog2(CACHE_DEPTH);

   typedef enum logic [2:0] {IDLE, RX, ERR, TXREQ, TX} state_t;

   state_t        state;
   logic [4:0]    rx_idx;
   logic [4:0]    tx_idx;
   logic [15:0]   oper;
   logic [47:0]   sha;
   logic [31:0]   spa;
   logic [23:0]   tpa_hi;
   logic          sending;
   logic [KW-1:0] tx_k;
   logic [47:0]   tx_tha;
   logic [31:0]   tx_tpa;
   logic [7:0]    tx_oper;
`ifdef ARP_GRATUITOUS_EN
   logic          announce_pending;
`else
   logic          unused_announce;
   assign unused_announce = announce;
`endif

   logic          cache_valid [CACHE_DEPTH];
   logic [31:0]   cache_ip    [CACHE_DEPTH];
   logic [47:0]   cache_mac   [CACHE_DEPTH];
   logic [PW-1:0] ptr;

   logic [4:0]    cur_idx;
   logic [7:0]    hdr_byte;
   logic          hdr_bad;
   logic [31:0]   tpa_full;
   logic          ip_found;
   logic [KW-1:0] ip_k;
   logic          learn;
   logic          wr_hit;
   logic [PW-1:0] wr_idx;
   logic          lk_hit;
   logic [47:0]   lk_mac;
   logic [239:0]  tx_frame;
   logic [4:0]    tx_sel;

   // Fixed header bytes; byte 0 is examined while still in IDLE
   always_comb begin
      cur_idx  = (state == IDLE) ? 5'd0 : rx_idx;
      hdr_byte = 8'h00;
      case (cur_idx)
         5'd0: hdr_byte = 8'h08;
         5'd1: hdr_byte = 8'h06;
         5'd2: hdr_byte = 8'h00;
         5'd3: hdr_byte = 8'h01;
         5'd4: hdr_byte = 8'h08;
         5'd5: hdr_byte = 8'h00;
         5'd6: hdr_byte = 8'h06;
         5'd7: hdr_byte = 8'h04;
         default: hdr_byte = 8'h00;
      endcase
      hdr_bad = ((cur_idx < 5'd2) || (STRICT_HDR != 0 && cur_idx < 5'd8)) && (rx_data != hdr_byte);
   end

   // Target address match, descending loop so the lowest index wins
   always_comb begin
      tpa_full = {tpa_hi, rx_data};
      ip_found = 1'b0;
      ip_k     = '0;
      for (int k = NUM_IP - 1; k >= 0; k--) begin
         if (local_ip[32*k +: 32] == tpa_full) begin
            ip_found = 1'b1;
            ip_k     = KW'(k);
         end
      end
   end

   assign learn = (state == RX) && rx_enable && (rx_idx == 5'd29) && !hdr_bad &&
                  ((oper == 16'd1) || (oper == 16'd2)) && ip_found;

   always_comb begin
      wr_hit = 1'b0;
      wr_idx = '0;
      lk_hit = 1'b0;
      lk_mac = '0;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
         if (cache_valid[i] && cache_ip[i] == spa) begin
            wr_hit = 1'b1;
            wr_idx = PW'(i);
         end
         if (cache_valid[i] && cache_ip[i] == lookup_ip) begin
            lk_hit = 1'b1;
            lk_mac = cache_mac[i];
         end
      end
   end

   // Main receive/transmit state machine
   always_ff @(posedge rx_clock) begin
      if (reset) begin
         state           <= IDLE;
         rx_idx          <= '0;
         tx_idx          <= '0;
         oper            <= '0;
         sha             <= '0;
         spa             <= '0;
         tpa_hi          <= '0;
         tx_request      <= 1'b0;
         sending         <= 1'b0;
         destination_mac <= '0;
         tx_k            <= '0;
         tx_tha          <= '0;
         tx_tpa          <= '0;
         tx_oper         <= '0;
`ifdef ARP_GRATUITOUS_EN
         announce_pending <= 1'b1;
`endif
      end else begin
`ifdef ARP_GRATUITOUS_EN
         if (announce)
            announce_pending <= 1'b1;
`endif
         case (state)
            IDLE: begin
`ifdef ARP_GRATUITOUS_EN
               if (announce_pending) begin
                  announce_pending <= announce;
                  state            <= TXREQ;
                  tx_request       <= 1'b1;
                  destination_mac  <= '1;
                  tx_k             <= '0;
                  tx_tha           <= '0;
                  tx_tpa           <= local_ip[31:0];
                  tx_oper          <= 8'd1;
               end else
`endif
               if (rx_enable) begin
                  state  <= hdr_bad ? ERR : RX;
                  rx_idx <= 5'd1;
               end
            end
            RX: begin
               if (!rx_enable) begin
                  state <= IDLE;
               end else if (hdr_bad) begin
                  state <= ERR;
               end else begin
                  if (rx_idx == 5'd8 || rx_idx == 5'd9)
                     oper <= {oper[7:0], rx_data};
                  if (rx_idx >= 5'd10 && rx_idx <= 5'd15)
                     sha <= {sha[39:0], rx_data};
                  if (rx_idx >= 5'd16 && rx_idx <= 5'd19)
                     spa <= {spa[23:0], rx_data};
                  if (rx_idx >= 5'd26 && rx_idx <= 5'd28)
                     tpa_hi <= {tpa_hi[15:0], rx_data};
                  if (rx_idx == 5'd29) begin
                     if (learn && oper == 16'd1) begin
                        state           <= TXREQ;
                        tx_request      <= 1'b1;
                        destination_mac <= sha;
                        tx_k            <= ip_k;
                        tx_tha          <= sha;
                        tx_tpa          <= spa;
                        tx_oper         <= 8'd2;
                     end else begin
                        state <= ERR;
                     end
                  end else begin
                     rx_idx <= rx_idx + 5'd1;
                  end
               end
            end
            ERR: begin
               if (!rx_enable)
                  state <= IDLE;
            end
            TXREQ: begin
               if (tx_enable) begin
                  state      <= TX;
                  tx_request <= 1'b0;
                  sending    <= 1'b1;
                  tx_idx     <= 5'd1;
               end
            end
            TX: begin
               if (tx_idx == 5'd29) begin
                  state   <= IDLE;
                  sending <= 1'b0;
                  tx_idx  <= '0;
               end else begin
                  tx_idx <= tx_idx + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Refresh an existing entry in place; only new addresses consume the round-robin slot
   always_ff @(posedge rx_clock) begin
      if (reset) begin
         for (int i = 0; i < CACHE_DEPTH; i++) begin
            cache_valid[i] <= 1'b0;
            cache_ip[i]    <= '0;
            cache_mac[i]   <= '0;
         end
         ptr <= '0;
      end else if (learn) begin
         if (wr_hit) begin
            cache_mac[wr_idx] <= sha;
         end else begin
            cache_valid[ptr] <= 1'b1;
            cache_ip[ptr]    <= spa;
            cache_mac[ptr]   <= sha;
            ptr              <= (ptr == PW'(CACHE_DEPTH - 1)) ? '0 : ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge rx_clock) begin
      if (reset) begin
         lookup_done <= 1'b0;
         lookup_hit  <= 1'b0;
         lookup_mac  <= '0;
      end else begin
         lookup_done <= lookup_req;
         lookup_hit  <= lookup_req && lk_hit;
         lookup_mac  <= (lookup_req && lk_hit) ? lk_mac : 48'd0;
      end
   end

   always_comb begin
      tx_sel   = sending ? tx_idx : 5'd0;
      tx_frame = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, tx_oper,
                  local_mac, local_ip[32*tx_k +: 32], tx_tha, tx_tpa};
      tx_data  = tx_frame[8*(29 - int'(tx_sel)) +: 8];
   end

   assign tx_active = tx_enable | sending;

endmodule

// File: tb/tb_arp_responder_mc.sv
// Scoreboard bench for arp_responder_mc: expected TX bytes and lookup results are queued
// as stimulus is applied and compared when the DUT presents them.
module tb_arp_responder_mc;

   localparam logic [31:0] IP0 = 32'hc0a8010a;
   localparam logic [31:0] IP1 = 32'hc0a80114;
   localparam logic [47:0] MAC = 48'h020000000001;

   logic          rx_clock = 1'b0;
   logic          reset;
   logic          rx_enable;
   logic [7:0]    rx_data;
   logic [47:0]   local_mac;
   logic [63:0]   local_ip;
   logic          announce;
   logic          tx_enable;
   logic          tx_request;
   logic          tx_active;
   logic [7:0]    tx_data;
   logic [47:0]   destination_mac;
   logic          lookup_req;
   logic [31:0]   lookup_ip;
   logic          lookup_done;
   logic          lookup_hit;
   logic [47:0]   lookup_mac;

   int            err_count = 0;
   int            check_count = 0;
   logic [7:0]    tx_q [$];
   logic [48:0]   lk_q [$];
   logic [7:0]    exp_byte;
   logic [48:0]   exp_lk;

   arp_responder_mc #(.NUM_IP(2), .CACHE_DEPTH(4), .STRICT_HDR(1)) dut (
      .rx_clock(rx_clock), .reset(reset), .rx_enable(rx_enable), .rx_data(rx_data),
      .local_mac(local_mac), .local_ip(local_ip), .announce(announce),
      .tx_enable(tx_enable), .tx_request(tx_request), .tx_active(tx_active),
      .tx_data(tx_data), .destination_mac(destination_mac),
      .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_done(lookup_done),
      .lookup_hit(lookup_hit), .lookup_mac(lookup_mac)
   );

   always #5 rx_clock = ~rx_clock;

   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [239:0] build_frame(input logic [15:0] etype, input logic [15:0] op,
                                                input logic [47:0] sha, input logic [31:0] spa,
                                                input logic [47:0] tha, input logic [31:0] tpa);
      return {etype, 16'h0001, 16'h0800, 8'h06, 8'h04, op, sha, spa, tha, tpa};
   endfunction

   // Outputs are sampled on the falling edge, away from the active edge
   always @(negedge rx_clock) begin
      if (tx_active === 1'b1) begin
         if (tx_q.size() == 0) begin
            check_output("tx_active_idle", 64'(tx_active), 64'd0);
         end else begin
            exp_byte = tx_q.pop_front();
            check_output("tx_byte", 64'(tx_data), 64'(exp_byte));
         end
      end
      if (lookup_done === 1'b1) begin
         if (lk_q.size() == 0) begin
            check_output("lookup_done_idle", 64'(lookup_done), 64'd0);
         end else begin
            exp_lk = lk_q.pop_front();
            check_output("lookup_hit", 64'(lookup_hit), 64'(exp_lk[48]));
            check_output("lookup_mac", 64'(lookup_mac), 64'(exp_lk[47:0]));
         end
      end
   end

   task automatic apply_stimulus(input logic [239:0] f, input int nbytes, input logic expect_req);
      for (int i = 0; i < nbytes; i++) begin
         @(posedge rx_clock); #1;
         rx_enable = 1'b1;
         if (i < 30) rx_data = f[239 - 8*i -: 8];
         else        rx_data = 8'h00;
         if (i == 29) check_output("tx_request_early", 64'(tx_request), 64'd0);
      end
      @(posedge rx_clock); #1;
      rx_enable = 1'b0;
      rx_data   = 8'h00;
      check_output("tx_request_after", 64'(tx_request), 64'(expect_req));
      repeat (2) @(posedge rx_clock);
      #1;
   endtask

   task automatic expect_reply(input logic [31:0] ip, input logic [47:0] sha, input logic [31:0] spa);
      logic [239:0] f;
      f = build_frame(16'h0806, 16'd2, MAC, ip, sha, spa);
      for (int i = 0; i < 30; i++) tx_q.push_back(f[239 - 8*i -: 8]);
   endtask

   task automatic grant_and_drain();
      @(posedge rx_clock); #1;
      tx_enable = 1'b1;
      @(posedge rx_clock); #1;
      tx_enable = 1'b0;
      check_output("tx_request_granted", 64'(tx_request), 64'd0);
      repeat (32) @(posedge rx_clock);
      #1;
      check_output("tx_q_drained", 64'(tx_q.size()), 64'd0);
      check_output("tx_active_end", 64'(tx_active), 64'd0);
   endtask

   task automatic do_lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac);
      @(posedge rx_clock); #1;
      lookup_req = 1'b1;
      lookup_ip  = ip;
      lk_q.push_back({hit, mac});
      @(posedge rx_clock); #1;
      lookup_req = 1'b0;
      @(posedge rx_clock); #1;
      check_output("lookup_answered", 64'(lk_q.size()), 64'd0);
   endtask

   initial begin
      reset      = 1'b1;
      rx_enable  = 1'b0;
      rx_data    = 8'h00;
      local_mac  = MAC;
      local_ip   = {IP1, IP0};
      announce   = 1'b0;
      tx_enable  = 1'b0;
      lookup_req = 1'b0;
      lookup_ip  = 32'h0;
      repeat (2) @(posedge rx_clock);
      #1;
      reset = 1'b0;
      check_output("rst_tx_request", 64'(tx_request), 64'd0);
      check_output("rst_tx_active", 64'(tx_active), 64'd0);
      check_output("rst_tx_data", 64'(tx_data), 64'h08);
      check_output("rst_dest_mac", 64'(destination_mac), 64'd0);
      check_output("rst_lookup_done", 64'(lookup_done), 64'd0);
      check_output("rst_lookup_hit", 64'(lookup_hit), 64'd0);
      check_output("rst_lookup_mac", 64'(lookup_mac), 64'd0);

      // Request for the second local address
      apply_stimulus(build_frame(16'h0806, 16'd1, 48'h001122334455, 32'hc0a8014d, 48'h0, IP1), 30, 1'b1);
      check_output("dest_mac_req", 64'(destination_mac), 64'h001122334455);
      expect_reply(IP1, 48'h001122334455, 32'hc0a8014d);
      grant_and_drain();
      do_lookup(32'hc0a8014d, 1'b1, 48'h001122334455);

      // Request for a foreign address is neither answered nor learned
      apply_stimulus(build_frame(16'h0806, 16'd1, 48'h0a0a0a0a0a0a, 32'h0a010101, 48'h0, 32'hc0a80163), 30, 1'b0);
      do_lookup(32'h0a010101, 1'b0, 48'h0);

      // Padded reply is learned without transmit
      apply_stimulus(build_frame(16'h0806, 16'd2, 48'haabbccddeeff, 32'h0a000005, MAC, IP0), 36, 1'b0);
      do_lookup(32'h0a000005, 1'b1, 48'haabbccddeeff);

      // Five new addresses into four slots, then a refresh and one more new address
      for (int n = 1; n <= 5; n++)
         apply_stimulus(build_frame(16'h0806, 16'd2, 48'h000000000100 + 48'(n), 32'h0a000100 + 32'(n), MAC, IP0), 30, 1'b0);
      do_lookup(32'h0a000101, 1'b0, 48'h0);
      do_lookup(32'h0a000105, 1'b1, 48'h000000000105);
      apply_stimulus(build_frame(16'h0806, 16'd2, 48'h0000000005ff, 32'h0a000105, MAC, IP0), 30, 1'b0);
      apply_stimulus(build_frame(16'h0806, 16'd2, 48'h000000000201, 32'h0a000201, MAC, IP0), 30, 1'b0);
      do_lookup(32'h0a000105, 1'b1, 48'h0000000005ff);
      do_lookup(32'h0a000103, 1'b1, 48'h000000000103);
      do_lookup(32'h0a000102, 1'b0, 48'h0);
      do_lookup(32'h0a000201, 1'b1, 48'h000000000201);

      // Truncated frame and wrong ethertype, then a valid request
      apply_stimulus(build_frame(16'h0806, 16'd1, 48'h0c0c0c0c0c0c, 32'h0a000303, 48'h0, IP0), 20, 1'b0);
      apply_stimulus(build_frame(16'h0800, 16'd1, 48'h0d0d0d0d0d0d, 32'h0a000304, 48'h0, IP0), 30, 1'b0);
      do_lookup(32'h0a000303, 1'b0, 48'h0);
      do_lookup(32'h0a000304, 1'b0, 48'h0);
      apply_stimulus(build_frame(16'h0806, 16'd1, 48'h665544332211, 32'h0a000305, 48'h0, IP0), 30, 1'b1);
      check_output("dest_mac_req2", 64'(destination_mac), 64'h665544332211);
      expect_reply(IP0, 48'h665544332211, 32'h0a000305);
      grant_and_drain();

      // Reset during byte 10 of a reply
      apply_stimulus(build_frame(16'h0806, 16'd1, 48'h0a0b0c0d0e0f, 32'h0a000404, 48'h0, IP0), 30, 1'b1);
      expect_reply(IP0, 48'h0a0b0c0d0e0f, 32'h0a000404);
      @(posedge rx_clock); #1;
      tx_enable = 1'b1;
      @(posedge rx_clock); #1;
      tx_enable = 1'b0;
      repeat (9) @(posedge rx_clock);
      #1;
      reset = 1'b1;
      @(posedge rx_clock); #1;
      check_output("rst_mid_tx_request", 64'(tx_request), 64'd0);
      check_output("rst_mid_tx_active", 64'(tx_active), 64'd0);
      tx_q.delete();
      reset = 1'b0;
      check_output("rst_mid_dest_mac", 64'(destination_mac), 64'd0);
      repeat (4) @(posedge rx_clock);
      #1;
      check_output("post_rst_tx_request", 64'(tx_request), 64'd0);
      do_lookup(32'h0a000404, 1'b0, 48'h0);

      check_output("tx_q_final", 64'(tx_q.size()), 64'd0);
      check_output("lk_q_final", 64'(lk_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
